// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: S-box tables, P-layer index, forward key update and FSM states.
// Used by both the encryptor and decryptor datapaths.
package present_pkg;

    localparam int unsigned BLK    = 64;
    localparam int unsigned KEY    = 80;
    localparam int unsigned ROUNDS = 31;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StKeygen = 3'd1,
        StWhiten = 3'd2,
        StRound  = 3'd3,
        StDone   = 3'd4
    } dec_state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Destination of bit i in the forward P-layer.
    function automatic logic [5:0] p_idx(input logic [5:0] i);
        logic [5:0] r;
        if (i == 6'd63) begin
            r = 6'd63;
        end else begin
            r = 6'((16 * int'(i)) % 63);
        end
        return r;
    endfunction

    // Forward key-schedule step producing the key for round i+1.
    function automatic logic [KEY-1:0] fk(input logic [KEY-1:0] k, input logic [4:0] i);
        logic [KEY-1:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ i;
        return t;
    endfunction

endpackage

// File: rtl/inv_sboxlayer.sv
// Sixteen parallel inverse PRESENT S-boxes across a 64-bit state word.
module inv_sboxlayer
    import present_pkg::*;
(
    input  logic [BLK-1:0] data_i,
    output logic [BLK-1:0] data_o
);

    for (genvar g = 0; g < 16; g++) begin : g_nib
        assign data_o[4*g +: 4] = sbox_inv(data_i[4*g +: 4]);
    end

endmodule

// File: rtl/present_dec_core.sv
// Iterative PRESENT-80 decryptor: forward key schedule to the last round key, then one
// inverse round per clock while stepping the key schedule backwards.
module present_dec_core
    import present_pkg::*;
(
    input  logic            CK,
    input  logic            RN,
    input  logic            start,
    input  logic [BLK-1:0]  ctext,
    input  logic [KEY-1:0]  key,
    output logic            busy,
    output logic            done,
    output logic [BLK-1:0]  ptext
);

    dec_state_e     state_q, state_d;
    logic [BLK-1:0] st_q, st_d;
    logic [KEY-1:0] kr_q, kr_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [KEY-1:0] kn;
    logic [BLK-1:0] pinv;
    logic [BLK-1:0] sbl_out;

    // Undoes fk: same steps in reverse order with inverse operations.
    function automatic logic [KEY-1:0] ik(input logic [KEY-1:0] k, input logic [4:0] i);
        logic [KEY-1:0] t;
        t        = k;
        t[19:15] = t[19:15] ^ i;
        t[79:76] = sbox_inv(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

    function automatic logic [BLK-1:0] p_inv(input logic [BLK-1:0] s);
        logic [BLK-1:0] o;
        o = '0;
        for (int j = 0; j < BLK; j++) begin
            o[j] = s[p_idx(6'(j))];
        end
        return o;
    endfunction

    assign kn   = ik(kr_q, cnt_q);
    assign pinv = p_inv(st_q);

    inv_sboxlayer u_inv_sboxlayer (
        .data_i (pinv),
        .data_o (sbl_out)
    );

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        kr_d    = kr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    st_d    = ctext;
                    kr_d    = key;
                    cnt_d   = 5'd1;
                    state_d = StKeygen;
                end
            end
            StKeygen: begin
                kr_d  = fk(kr_q, cnt_q);
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ROUNDS)) begin
                    state_d = StWhiten;
                end
            end
            StWhiten: begin
                st_d    = st_q ^ kr_q[79:16];
                cnt_d   = 5'(ROUNDS);
                state_d = StRound;
            end
            StRound: begin
                kr_d  = kn;
                st_d  = sbl_out ^ kn[79:16];
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        // Outputs are decoded from the next state so they register in step with it.
        busy_d = (state_d == StKeygen) || (state_d == StWhiten) || (state_d == StRound);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= StIdle;
            st_q    <= '0;
            kr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            kr_q    <= kr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign ptext = st_q;

endmodule

// File: tb/tb_present_dec_core.sv
// Self-checking bench for present_dec_core: known-answer table, corner sequences and
// random encrypt-then-decrypt round trips against an independent encryption model.
module tb_present_dec_core;

    logic        CK;
    logic        RN;
    logic        start;
    logic [63:0] ctext;
    logic [79:0] key;
    logic        busy;
    logic        done;
    logic [63:0] ptext;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] sb_q[$];

    typedef struct {
        logic [63:0] c;
        logic [79:0] k;
        logic [63:0] p;
    } vec_t;

    vec_t tbl[5];

    logic [3:0] sb_tab[16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_dec_core dut (
        .CK    (CK),
        .RN    (RN),
        .start (start),
        .ctext (ctext),
        .key   (key),
        .busy  (busy),
        .done  (done),
        .ptext (ptext)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Reference PRESENT-80 encryption, written straight from the cipher description.
    function automatic logic [63:0] enc(input logic [63:0] pt, input logic [79:0] k);
        logic [63:0] s;
        logic [63:0] t;
        logic [79:0] kk;
        logic [4:0]  rc;
        s  = pt;
        kk = k;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ kk[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb_tab[s[4*n +: 4]];
            t = '0;
            for (int b = 0; b < 63; b++) t[(16 * b) % 63] = s[b];
            t[63] = s[63];
            s  = t;
            kk = {kk[18:0], kk[79:19]};
            kk[79:76] = sb_tab[kk[79:76]];
            rc = 5'(r);
            kk[19:15] = kk[19:15] ^ rc;
        end
        return s ^ kk[79:16];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves start asserted across exactly one rising edge.
    task automatic start_op(input logic [63:0] c, input logic [79:0] k, input logic [63:0] p);
        start = 1'b1;
        ctext = c;
        key   = k;
        sb_q.push_back(p);
        @(negedge CK);
        start = 1'b0;
    endtask

    // From the negedge after acceptance, wait for done; report latency and busy cycles.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            @(negedge CK);
            lat++;
        end
    endtask

    task automatic finish_op(input string name, input int exp_lat, input int exp_bcnt,
                             input int lat, input int bcnt);
        logic [63:0] exp;
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        if (exp_bcnt >= 0) chk({name, " busy_cycles"}, 64'(bcnt), 64'(exp_bcnt));
        chk({name, " busy_with_done"}, {63'd0, busy}, 64'd0);
        if (sb_q.size() == 0) begin
            chk({name, " scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            chk({name, " ptext"}, ptext, exp);
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        logic [31:0] r0;
        logic [63:0] pt;
        logic [79:0] kk;

        tbl[0] = '{c: 64'h5579C1387B228445, k: 80'h0,                    p: 64'h0};
        tbl[1] = '{c: 64'hE72C46C0F5945049, k: 80'hFFFFFFFFFFFFFFFFFFFF, p: 64'h0};
        tbl[2] = '{c: 64'h3333DCD3213210D2, k: 80'hFFFFFFFFFFFFFFFFFFFF, p: 64'hFFFFFFFFFFFFFFFF};
        tbl[3] = '{c: 64'hA112FFC72F68417B, k: 80'h0,                    p: 64'hFFFFFFFFFFFFFFFF};
        tbl[4] = '{c: 64'h3333DCD3213210D2, k: 80'hFFFFFFFFFFFFFFFFFFFF, p: 64'hFFFFFFFFFFFFFFFF};

        RN    = 1'b0;
        start = 1'b0;
        ctext = '0;
        key   = '0;
        #3;
        chk("reset busy",  {63'd0, busy}, 64'd0);
        chk("reset done",  {63'd0, done}, 64'd0);
        chk("reset ptext", ptext, 64'd0);
        repeat (2) @(negedge CK);
        RN = 1'b1;
        @(negedge CK);
        chk("idle busy", {63'd0, busy}, 64'd0);
        chk("idle done", {63'd0, done}, 64'd0);

        // Known answers; each start lands in the first DONE cycle of the previous one.
        for (int i = 0; i < 5; i++) begin
            start_op(tbl[i].c, tbl[i].k, tbl[i].p);
            chk($sformatf("kat%0d done_dropped", i), {63'd0, done}, 64'd0);
            wait_done(lat, bcnt);
            finish_op($sformatf("kat%0d", i), 63, 63, lat, bcnt);
        end

        // Start and input changes during busy must be ignored.
        @(negedge CK);
        start_op(tbl[3].c, tbl[3].k, tbl[3].p);
        repeat (20) @(negedge CK);
        start = 1'b1;
        ctext = 64'h0123456789ABCDEF;
        key   = 80'h13579BDF02468ACE1357;
        @(negedge CK);
        start = 1'b0;
        ctext = 64'hDEADBEEFCAFEF00D;
        key   = '1;
        wait_done(lat, bcnt);
        finish_op("busy_start", 42, -1, lat, bcnt);

        // Reset part-way through an operation aborts it with no result flagged.
        @(negedge CK);
        start_op(tbl[1].c, tbl[1].k, tbl[1].p);
        repeat (40) @(negedge CK);
        chk("pre_abort busy", {63'd0, busy}, 64'd1);
        RN = 1'b0;
        #1;
        chk("abort busy",  {63'd0, busy}, 64'd0);
        chk("abort done",  {63'd0, done}, 64'd0);
        chk("abort ptext", ptext, 64'd0);
        sb_q.delete();
        @(negedge CK);
        RN = 1'b1;
        repeat (3) @(negedge CK);
        chk("post_abort done", {63'd0, done}, 64'd0);
        start_op(tbl[0].c, tbl[0].k, tbl[0].p);
        wait_done(lat, bcnt);
        finish_op("after_abort", 63, 63, lat, bcnt);

        // Random round trips through the reference encryptor.
        for (int i = 0; i < 400; i++) begin
            r0 = $urandom;
            pt = {$urandom, $urandom};
            kk = {r0[15:0], $urandom, $urandom};
            start_op(enc(pt, kk), kk, pt);
            wait_done(lat, bcnt);
            if (lat != 63 || ptext !== pt) begin
                finish_op($sformatf("rand%0d", i), 63, -1, lat, bcnt);
            end else begin
                void'(sb_q.pop_front());
                n_cmp++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
